// File: rtl/axi4lite_slave_regs.sv
// rtl/axi4lite_slave_regs.sv - AXI4-Lite responder with a 4-entry register file (CTRL, DATA, SCRATCH, read-only ID)
module axi4lite_slave_regs #(
    parameter int C_S_AXI_ADDR_WIDTH = 2,
    parameter int C_S_AXI_DATA_WIDTH = 8,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] ID_VALUE = 8'hA5
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg_ctrl,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg_data,
    output logic                            wr_pulse,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_pulse_addr
);

    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_CTRL    = C_S_AXI_ADDR_WIDTH'(0);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_DATA    = C_S_AXI_ADDR_WIDTH'(1);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_SCRATCH = C_S_AXI_ADDR_WIDTH'(2);

    logic [C_S_AXI_DATA_WIDTH-1:0] reg_scratch;
    logic                          aw_full, w_full;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic                          w_strb_q;

    logic                          aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                          commit, wr_en, ro_addr, commit_strb;
    logic [C_S_AXI_ADDR_WIDTH-1:0] commit_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] commit_data, rd_value;

    always_comb begin
        aw_hs       = s_axi_awvalid & s_axi_awready;
        w_hs        = s_axi_wvalid & s_axi_wready;
        ar_hs       = s_axi_arvalid & s_axi_arready;
        b_hs        = s_axi_bvalid & s_axi_bready;
        r_hs        = s_axi_rvalid & s_axi_rready;
        // A half latched at an earlier edge takes precedence over the live bus
        commit_addr = aw_full ? aw_addr_q : s_axi_awaddr;
        commit_data = w_full ? w_data_q : s_axi_wdata;
        commit_strb = w_full ? w_strb_q : s_axi_wstrb[0];
        commit      = (aw_full | aw_hs) & (w_full | w_hs) & ~s_axi_bvalid;
        ro_addr     = (commit_addr != ADDR_CTRL) && (commit_addr != ADDR_DATA) &&
                      (commit_addr != ADDR_SCRATCH);
        wr_en       = commit & commit_strb & ~ro_addr;
        case (s_axi_araddr)
            ADDR_CTRL:    rd_value = reg_ctrl;
            ADDR_DATA:    rd_value = reg_data;
            ADDR_SCRATCH: rd_value = reg_scratch;
            default:      rd_value = ID_VALUE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            reg_ctrl      <= '0;
            reg_data      <= '0;
            reg_scratch   <= '0;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= 2'b00;
            wr_pulse      <= 1'b0;
            wr_pulse_addr <= '0;
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb[0];
            end

            // Readies rise on the first edge out of reset and after each B handshake
            if (b_hs) begin
                aw_full       <= 1'b0;
                w_full        <= 1'b0;
                s_axi_bvalid  <= 1'b0;
                s_axi_bresp   <= 2'b00;
                s_axi_awready <= 1'b1;
                s_axi_wready  <= 1'b1;
            end else begin
                s_axi_awready <= ~(aw_full | aw_hs);
                s_axi_wready  <= ~(w_full | w_hs);
            end

            wr_pulse <= wr_en;
            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= ro_addr ? 2'b10 : 2'b00;
            end
            if (wr_en) begin
                wr_pulse_addr <= commit_addr;
                case (commit_addr)
                    ADDR_CTRL: reg_ctrl    <= commit_data;
                    ADDR_DATA: reg_data    <= commit_data;
                    default:   reg_scratch <= commit_data;
                endcase
            end

            // rd_value is the pre-edge register file, so a same-edge write is not visible
            if (ar_hs) begin
                s_axi_rvalid  <= 1'b1;
                s_axi_rdata   <= rd_value;
                s_axi_rresp   <= 2'b00;
                s_axi_arready <= 1'b0;
            end else if (r_hs) begin
                s_axi_rvalid  <= 1'b0;
                s_axi_arready <= 1'b1;
            end else begin
                s_axi_arready <= ~s_axi_rvalid;
            end
        end
    end

endmodule
